// File: rtl/scancode_digit_ctrl_pkg.sv
// Shared constants for the scancode digit controller: scancodes, blank digit
// encoding and sequencer FSM state encoding.
package scancode_digit_ctrl_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_ESC    = 8'h76;

    localparam logic [4:0] DIG_BLANK = 5'h10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXT  = 2'd1,
        ST_BRK  = 2'd2
    } state_e;

    // Digit slots use bit 4 as the blank flag.
    function automatic logic dig_is_blank(input logic [4:0] dig);
        return dig[4];
    endfunction

endpackage

// File: rtl/scancode_digit_ctrl_to_hex.sv
// Combinational decode of a PS/2 set-2 make code into a hex key value.
module scancode_to_hex (
    input  logic [7:0] code_i,
    output logic       is_hex_o,
    output logic [3:0] nibble_o
);

    // Make-code lookup for keys 0-9 and A-F.
    always_comb begin
        is_hex_o = 1'b1;
        nibble_o = 4'h0;
        case (code_i)
            8'h45: nibble_o = 4'h0;
            8'h16: nibble_o = 4'h1;
            8'h1E: nibble_o = 4'h2;
            8'h26: nibble_o = 4'h3;
            8'h25: nibble_o = 4'h4;
            8'h2E: nibble_o = 4'h5;
            8'h36: nibble_o = 4'h6;
            8'h3D: nibble_o = 4'h7;
            8'h3E: nibble_o = 4'h8;
            8'h46: nibble_o = 4'h9;
            8'h1C: nibble_o = 4'hA;
            8'h32: nibble_o = 4'hB;
            8'h21: nibble_o = 4'hC;
            8'h23: nibble_o = 4'hD;
            8'h24: nibble_o = 4'hE;
            8'h2B: nibble_o = 4'hF;
            default: begin
                is_hex_o = 1'b0;
                nibble_o = 4'h0;
            end
        endcase
    end

endmodule

// File: rtl/scancode_digit_ctrl.sv
// PS/2 scancode sequencer feeding four 7-segment digit slots.
// Optional idle auto-clear is enabled by defining AUTO_CLEAR_EN.
module scancode_digit_ctrl
    import scancode_digit_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int          TMR_W          = 26
)
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       code_valid,
    input  logic [7:0] code,
    output logic [4:0] dig0,
    output logic [4:0] dig1,
    output logic [4:0] dig2,
    output logic [4:0] dig3,
    output logic [7:0] last_code,
    output logic       full,
    output logic       ovf
);

    state_e          state_q, state_d;
    logic [3:0][4:0] dig_q, dig_d;
    logic [7:0]      last_code_q, last_code_d;
    logic            ovf_q, ovf_d;
    logic            is_hex_s;
    logic [3:0]      nibble_s;
    logic            timeout_hit_s;

    scancode_to_hex u_to_hex (
        .code_i   (code),
        .is_hex_o (is_hex_s),
        .nibble_o (nibble_s)
    );

`ifdef AUTO_CLEAR_EN
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 32'd1);

    logic [TMR_W-1:0] tmr_q, tmr_d;

    // Idle counter: restarts on every byte, saturates at the timeout.
    always_comb begin
        tmr_d = tmr_q;
        if (code_valid) begin
            tmr_d = '0;
        end else if (tmr_q != TMR_MAX) begin
            tmr_d = tmr_q + TMR_W'(1);
        end else begin
            tmr_d = tmr_q;
        end
    end

    // Clear fires only on the transition into the timeout value.
    assign timeout_hit_s = ~code_valid & (tmr_q == TMR_LAST);

    // Idle counter register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Prefix FSM and digit shift-register next state.
    always_comb begin
        state_d     = state_q;
        dig_d       = dig_q;
        last_code_d = last_code_q;
        ovf_d       = 1'b0;
        if (code_valid) begin
            last_code_d = code;
            case (state_q)
                ST_IDLE: begin
                    if (code == SC_BREAK) begin
                        state_d = ST_BRK;
                    end else if (code == SC_EXT) begin
                        state_d = ST_EXT;
                    end else begin
                        state_d = ST_IDLE;
                        if (is_hex_s) begin
                            dig_d = {dig_q[2], dig_q[1], dig_q[0], {1'b0, nibble_s}};
                            ovf_d = ~dig_is_blank(dig_q[3]);
                        end else if (code == SC_BKSP) begin
                            dig_d = {DIG_BLANK, dig_q[3], dig_q[2], dig_q[1]};
                        end else if (code == SC_ESC) begin
                            dig_d = {4{DIG_BLANK}};
                        end else begin
                            dig_d = dig_q;
                        end
                    end
                end
                ST_EXT: begin
                    // Extended keys (arrows, keypad enter...) never touch the digits.
                    if (code == SC_BREAK) begin
                        state_d = ST_BRK;
                    end else if (code == SC_EXT) begin
                        state_d = ST_EXT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (timeout_hit_s) begin
            dig_d = {4{DIG_BLANK}};
        end else begin
            state_d = state_q;
        end
    end

    // State, digit and status registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            dig_q       <= {4{DIG_BLANK}};
            last_code_q <= 8'h00;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dig_q       <= dig_d;
            last_code_q <= last_code_d;
            ovf_q       <= ovf_d;
        end
    end

    assign dig0      = dig_q[0];
    assign dig1      = dig_q[1];
    assign dig2      = dig_q[2];
    assign dig3      = dig_q[3];
    assign last_code = last_code_q;
    assign ovf       = ovf_q;
    assign full      = ~dig_is_blank(dig_q[0]) & ~dig_is_blank(dig_q[1])
                     & ~dig_is_blank(dig_q[2]) & ~dig_is_blank(dig_q[3]);

endmodule

// File: tb/tb_scancode_digit_ctrl.sv
// Self-checking bench for scancode_digit_ctrl: directed vector table, corner
// sequences and randomized bytes checked against a queue-based digit model.
module tb_scancode_digit_ctrl;

    localparam int TO = 20;

    logic       CLK;
    logic       RST;
    logic       code_valid;
    logic [7:0] code;
    logic [4:0] dig0, dig1, dig2, dig3;
    logic [7:0] last_code;
    logic       full, ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    scancode_digit_ctrl #(.TIMEOUT_CYCLES(TO), .TMR_W(5)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .code_valid (code_valid),
        .code       (code),
        .dig0       (dig0),
        .dig1       (dig1),
        .dig2       (dig2),
        .dig3       (dig3),
        .last_code  (last_code),
        .full       (full),
        .ovf        (ovf)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- reference model ----------------
    // Entered hex values, oldest first; the display shows the last four right-aligned.
    int         mq[$];
    bit         m_brk, m_ext, m_ovf;
    logic [7:0] m_last;
    int         m_idle;

    logic [7:0] hex_codes [16];
    initial begin
        hex_codes = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                      8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
    end

    function automatic int hexval(logic [7:0] c);
        for (int i = 0; i < 16; i++) if (hex_codes[i] == c) return i;
        return -1;
    endfunction

    function automatic logic [19:0] model_digs();
        logic [19:0] r;
        for (int i = 0; i < 4; i++) begin
            if (i < mq.size()) r[i*5 +: 5] = {1'b0, 4'(mq[mq.size()-1-i])};
            else               r[i*5 +: 5] = 5'h10;
        end
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_brk = 1'b0; m_ext = 1'b0; m_ovf = 1'b0;
        m_last = 8'h00; m_idle = 0;
    endtask

    task automatic model_step(logic v, logic [7:0] c);
        int h;
        m_ovf = 1'b0;
        if (v) begin
            m_last = c;
            m_idle = 0;
            if (m_brk) m_brk = 1'b0;
            else if (c == 8'hF0) begin m_brk = 1'b1; m_ext = 1'b0; end
            else if (c == 8'hE0) m_ext = 1'b1;
            else if (m_ext) m_ext = 1'b0;
            else begin
                h = hexval(c);
                if (h >= 0) begin
                    mq.push_back(h);
                    if (mq.size() > 4) begin void'(mq.pop_front()); m_ovf = 1'b1; end
                end else if (c == 8'h66) begin
                    if (mq.size() > 0) void'(mq.pop_back());
                end else if (c == 8'h76) mq.delete();
            end
        end else begin
`ifdef AUTO_CLEAR_EN
            if (m_idle < TO) begin
                m_idle++;
                if (m_idle == TO) mq.delete();
            end
`endif
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        chk("digits", {12'h0, dig3, dig2, dig1, dig0}, {12'h0, model_digs()});
        chk("last_code", {24'h0, last_code}, {24'h0, m_last});
        chk("full", {31'h0, full}, {31'h0, 1'(mq.size() == 4)});
        chk("ovf", {31'h0, ovf}, {31'h0, m_ovf});
    endtask

    task automatic step(logic v, logic [7:0] c);
        code_valid = v;
        code       = c;
        @(posedge CLK);
        #1;
        code_valid = 1'b0;
        model_step(v, c);
        check_model();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic do_reset(logic v, logic [7:0] c);
        RST        = 1'b1;
        code_valid = v;
        code       = c;
        @(posedge CLK);
        #1;
        RST        = 1'b0;
        code_valid = 1'b0;
        model_reset();
        chk("reset_digits", {12'h0, dig3, dig2, dig1, dig0}, 32'h0008_4210);
        chk("reset_last", {24'h0, last_code}, 32'h0);
        chk("reset_full_ovf", {30'h0, full, ovf}, 32'h0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v;
        logic [7:0]  c;
        logic [19:0] digs;
        logic        ovf;
        logic        full;
        logic [7:0]  last;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [7:0] c, logic [4:0] d3, logic [4:0] d2,
                                logic [4:0] d1, logic [4:0] d0, logic o, logic f,
                                logic [7:0] l);
        vec_t r;
        r.v = v; r.c = c; r.digs = {d3, d2, d1, d0};
        r.ovf = o; r.full = f; r.last = l;
        return r;
    endfunction

    logic [7:0] pool [12];

    initial begin
        RST        = 1'b1;
        code_valid = 1'b0;
        code       = 8'h00;

        tbl.push_back(mk(1'b1, 8'h16, 5'h10, 5'h10, 5'h10, 5'h01, 1'b0, 1'b0, 8'h16));
        tbl.push_back(mk(1'b1, 8'h1E, 5'h10, 5'h10, 5'h01, 5'h02, 1'b0, 1'b0, 8'h1E));
        tbl.push_back(mk(1'b1, 8'h26, 5'h10, 5'h01, 5'h02, 5'h03, 1'b0, 1'b0, 8'h26));
        tbl.push_back(mk(1'b1, 8'h25, 5'h01, 5'h02, 5'h03, 5'h04, 1'b0, 1'b1, 8'h25));
        tbl.push_back(mk(1'b1, 8'h1C, 5'h02, 5'h03, 5'h04, 5'h0A, 1'b1, 1'b1, 8'h1C));
        tbl.push_back(mk(1'b0, 8'h00, 5'h02, 5'h03, 5'h04, 5'h0A, 1'b0, 1'b1, 8'h1C));
        tbl.push_back(mk(1'b1, 8'h76, 5'h10, 5'h10, 5'h10, 5'h10, 1'b0, 1'b0, 8'h76));
        tbl.push_back(mk(1'b1, 8'h16, 5'h10, 5'h10, 5'h10, 5'h01, 1'b0, 1'b0, 8'h16));
        tbl.push_back(mk(1'b1, 8'hF0, 5'h10, 5'h10, 5'h10, 5'h01, 1'b0, 1'b0, 8'hF0));
        tbl.push_back(mk(1'b1, 8'h16, 5'h10, 5'h10, 5'h10, 5'h01, 1'b0, 1'b0, 8'h16));
        tbl.push_back(mk(1'b1, 8'hE0, 5'h10, 5'h10, 5'h10, 5'h01, 1'b0, 1'b0, 8'hE0));
        tbl.push_back(mk(1'b1, 8'h75, 5'h10, 5'h10, 5'h10, 5'h01, 1'b0, 1'b0, 8'h75));
        tbl.push_back(mk(1'b1, 8'hE0, 5'h10, 5'h10, 5'h10, 5'h01, 1'b0, 1'b0, 8'hE0));
        tbl.push_back(mk(1'b1, 8'hF0, 5'h10, 5'h10, 5'h10, 5'h01, 1'b0, 1'b0, 8'hF0));
        tbl.push_back(mk(1'b1, 8'h75, 5'h10, 5'h10, 5'h10, 5'h01, 1'b0, 1'b0, 8'h75));
        tbl.push_back(mk(1'b1, 8'h1E, 5'h10, 5'h10, 5'h01, 5'h02, 1'b0, 1'b0, 8'h1E));
        tbl.push_back(mk(1'b1, 8'h26, 5'h10, 5'h01, 5'h02, 5'h03, 1'b0, 1'b0, 8'h26));
        tbl.push_back(mk(1'b1, 8'h25, 5'h01, 5'h02, 5'h03, 5'h04, 1'b0, 1'b1, 8'h25));
        tbl.push_back(mk(1'b1, 8'h66, 5'h10, 5'h01, 5'h02, 5'h03, 1'b0, 1'b0, 8'h66));
        tbl.push_back(mk(1'b1, 8'h76, 5'h10, 5'h10, 5'h10, 5'h10, 1'b0, 1'b0, 8'h76));
        tbl.push_back(mk(1'b1, 8'h66, 5'h10, 5'h10, 5'h10, 5'h10, 1'b0, 1'b0, 8'h66));
        tbl.push_back(mk(1'b1, 8'h45, 5'h10, 5'h10, 5'h10, 5'h00, 1'b0, 1'b0, 8'h45));
        tbl.push_back(mk(1'b1, 8'hE0, 5'h10, 5'h10, 5'h10, 5'h00, 1'b0, 1'b0, 8'hE0));
        tbl.push_back(mk(1'b1, 8'h66, 5'h10, 5'h10, 5'h10, 5'h00, 1'b0, 1'b0, 8'h66));
        tbl.push_back(mk(1'b1, 8'h45, 5'h10, 5'h10, 5'h00, 5'h00, 1'b0, 1'b0, 8'h45));
        tbl.push_back(mk(1'b1, 8'h2B, 5'h10, 5'h00, 5'h00, 5'h0F, 1'b0, 1'b0, 8'h2B));

        // Reset held for two edges with a strobe present: byte must be ignored.
        code_valid = 1'b1;
        code       = 8'h16;
        @(posedge CLK);
        do_reset(1'b1, 8'h16);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].c);
            chk($sformatf("tbl%0d_digits", i), {12'h0, dig3, dig2, dig1, dig0}, {12'h0, tbl[i].digs});
            chk($sformatf("tbl%0d_ovf_full", i), {30'h0, ovf, full}, {30'h0, tbl[i].ovf, tbl[i].full});
            chk($sformatf("tbl%0d_last", i), {24'h0, last_code}, {24'h0, tbl[i].last});
        end

        // Reset after a break prefix abandons it: next make code is acted on.
        step(1'b1, 8'hF0);
        do_reset(1'b0, 8'h00);
        step(1'b1, 8'h16);
        chk("post_reset_prefix", {27'h0, dig0}, 32'h01);

        // Idle timeout behaviour.
        do_reset(1'b0, 8'h00);
        step(1'b1, 8'h45);
`ifdef AUTO_CLEAR_EN
        idle(TO);
        chk("autoclear", {12'h0, dig3, dig2, dig1, dig0}, 32'h0008_4210);
        step(1'b1, 8'h45);
        idle(TO - 1);
        step(1'b1, 8'h45);
        idle(1);
        chk("strobe_beats_clear", {12'h0, dig3, dig2, dig1, dig0}, 32'h0008_4000);
`else
        idle(3 * TO);
        chk("digits_hold", {12'h0, dig3, dig2, dig1, dig0}, 32'h0008_4200);
`endif

        // Randomized bytes against the model.
        pool = '{8'h45, 8'h16, 8'h3E, 8'h1C, 8'h2B, 8'h24, 8'hF0, 8'hE0,
                 8'h66, 8'h76, 8'h75, 8'h5A};
        do_reset(1'b0, 8'h00);
        for (int n = 0; n < 600; n++) begin
            logic [7:0] b;
            if ($urandom_range(0, 3) == 0) b = 8'($urandom);
            else b = pool[$urandom_range(0, 11)];
            if ($urandom_range(0, 9) < 7) step(1'b1, b);
            else step(1'b0, 8'h00);
            if ($urandom_range(0, 49) == 0) idle(TO + 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
